// File: rtl/mips_regfile_sb.sv
// MIPS-style register file: two write ports, two combinational read ports with write bypass,
// and a per-register busy (pending producer) scoreboard with a registered population count.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_busy_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_zero;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_set_ok;
  logic              w_hit1;
  logic              w_hit2;

  assign w_zero   = (ZERO_REG != 0);
  assign w_wr0_ok = we0 && !(w_zero && (wa0 == '0));
  assign w_wr1_ok = we1 && !(w_zero && (wa1 == '0));
  assign w_set_ok = set_busy && !(w_zero && (busy_addr == '0));

  // Port 1 is the later NBA, so it wins on an address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wa0] <= wd0;
      if (w_wr1_ok) r_mem[wa1] <= wd1;
    end
  end

  // Clears first, then the set, so a same-cycle set survives the write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we0) w_busy_nxt[wa0] = 1'b0;
    if (we1) w_busy_nxt[wa1] = 1'b0;
    if (w_set_ok) w_busy_nxt[busy_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  always_comb begin
    rd1 = r_mem[ra1];
    if (w_zero && (ra1 == '0)) rd1 = '0;
    else if (we1 && (wa1 == ra1)) rd1 = wd1;
    else if (we0 && (wa0 == ra1)) rd1 = wd0;
  end

  always_comb begin
    rd2 = r_mem[ra2];
    if (w_zero && (ra2 == '0)) rd2 = '0;
    else if (we1 && (wa1 == ra2)) rd2 = wd1;
    else if (we0 && (wa0 == ra2)) rd2 = wd0;
  end

  // A write landing this cycle resolves the hazard, so busy is masked early.
  assign w_hit1 = (we0 && (wa0 == ra1)) || (we1 && (wa1 == ra1));
  assign w_hit2 = (we0 && (wa0 == ra2)) || (we1 && (wa1 == ra2));
  assign busy1  = r_busy[ra1] && !w_hit1;
  assign busy2  = r_busy[ra2] && !w_hit2;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb: writes, bypass, zero register, busy scoreboard and async reset.
module tb_mips_regfile_sb;

  logic        clk;
  logic        reset_n;
  logic        we0, we1, set_busy;
  logic [4:0]  wa0, wa1, ra1, ra2, busy_addr;
  logic [31:0] wd0, wd1, rd1, rd2;
  logic        busy1, busy2;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .set_busy(set_busy), .busy_addr(busy_addr),
    .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; set_busy = 1'b0;
  endtask

  task automatic mark(input logic [4:0] a);
    set_busy = 1'b1; busy_addr = a;
    tick();
    set_busy = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    ra1 = 0; ra2 = 0; set_busy = 0; busy_addr = 0;
    #2;
    check("rst_cnt", 32'(busy_cnt), 32'd0);
    ra1 = 5'd3;
    #1;
    check("rst_rd1", rd1, 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // single write, bypass and registered read
    we0 = 1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; ra1 = 5'd3; ra2 = 5'd0;
    #1;
    check("byp_w0", rd1, 32'hDEADBEEF);
    tick(); idle();
    #1;
    check("rd_r3", rd1, 32'hDEADBEEF);
    check("rd_r0", rd2, 32'd0);

    // same-address collision: port 1 wins
    we0 = 1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1; wa1 = 5'd7; wd1 = 32'h22; ra1 = 5'd7;
    #1;
    check("byp_coll", rd1, 32'h22);
    tick(); idle();
    #1;
    check("st_coll", rd1, 32'h22);

    // different addresses: both stored
    we0 = 1; wa0 = 5'd10; wd0 = 32'hAAAA; we1 = 1; wa1 = 5'd11; wd1 = 32'hBBBB;
    tick(); idle();
    ra1 = 5'd10; ra2 = 5'd11;
    #1;
    check("dual_w0", rd1, 32'hAAAA);
    check("dual_w1", rd2, 32'hBBBB);

    // zero register: write, bypass and busy all suppressed
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; set_busy = 1; busy_addr = 5'd0; ra1 = 5'd0;
    #1;
    check("z_byp", rd1, 32'd0);
    check("z_busy1", 32'(busy1), 32'd0);
    tick(); idle();
    #1;
    check("z_rd", rd1, 32'd0);
    check("z_cnt", 32'(busy_cnt), 32'd0);

    // busy set and cleared by a write
    mark(5'd5);
    check("cnt_1", 32'(busy_cnt), 32'd1);
    mark(5'd9);
    ra1 = 5'd5; ra2 = 5'd9;
    #1;
    check("cnt_2", 32'(busy_cnt), 32'd2);
    check("busy1_5", 32'(busy1), 32'd1);
    check("busy2_9", 32'(busy2), 32'd1);
    we1 = 1; wa1 = 5'd5; wd1 = 32'h55;
    #1;
    check("busy1_mask", 32'(busy1), 32'd0);
    check("busy2_hold", 32'(busy2), 32'd1);
    tick(); idle();
    #1;
    check("cnt_clr", 32'(busy_cnt), 32'd1);
    check("busy1_clr", 32'(busy1), 32'd0);
    check("rd_r5", rd1, 32'h55);

    // set beats a same-cycle write on an already busy register
    set_busy = 1; busy_addr = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
    tick(); idle();
    #1;
    check("setwin_cnt", 32'(busy_cnt), 32'd1);
    check("setwin_b2", 32'(busy2), 32'd1);
    check("setwin_rd", rd2, 32'h99);

    // re-marking a busy register leaves the count alone
    mark(5'd5);
    check("cnt_5_9", 32'(busy_cnt), 32'd2);
    mark(5'd5);
    check("remark", 32'(busy_cnt), 32'd2);

    // two clears in one cycle
    we0 = 1; wa0 = 5'd5; wd0 = 32'h505; we1 = 1; wa1 = 5'd9; wd1 = 32'h909;
    tick(); idle();
    #1;
    check("dec2", 32'(busy_cnt), 32'd0);

    // a write to a non-busy register keeps the count
    mark(5'd12);
    we0 = 1; wa0 = 5'd20; wd0 = 32'h20;
    tick(); idle();
    #1;
    check("wr_nonbusy", 32'(busy_cnt), 32'd1);

    // net -1: two clears plus one new set in one cycle
    mark(5'd13);
    mark(5'd14);
    we0 = 1; wa0 = 5'd12; wd0 = 32'h12; we1 = 1; wa1 = 5'd13; wd1 = 32'h13;
    set_busy = 1; busy_addr = 5'd15;
    tick(); idle();
    #1;
    check("net_m1", 32'(busy_cnt), 32'd2);
    mark(5'd5);
    check("cnt_3", 32'(busy_cnt), 32'd3);

    // async reset between edges
    ra1 = 5'd3; ra2 = 5'd5;
    #1;
    check("pre_b2", 32'(busy2), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_rd1", rd1, 32'd0);
    check("arst_b2", 32'(busy2), 32'd0);
    check("arst_cnt", 32'(busy_cnt), 32'd0);

    // while in reset: bypass visible, write and set ignored
    we0 = 1; wa0 = 5'd4; wd0 = 32'h44; ra1 = 5'd4; set_busy = 1; busy_addr = 5'd6;
    #1;
    check("rst_byp", rd1, 32'h44);
    tick(); idle();
    #1;
    check("rst_nowr", rd1, 32'd0);
    check("rst_noset", 32'(busy_cnt), 32'd0);
    reset_n = 1'b1;
    tick();
    ra2 = 5'd6;
    #1;
    check("post_cnt", 32'(busy_cnt), 32'd0);
    check("post_b2", 32'(busy2), 32'd0);
    mark(5'd6);
    check("post_mark", 32'(busy_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
